// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one word read in flight
// to instruction memory and queues returned {pc,insn} pairs for decode.
module fetch #(
  parameter logic [31:0] START_PC  = 32'h8002_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic        memRespValid,
  input  logic [31:0] memRespData,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        insn_valid
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, req_pc;
  logic [CW-1:0] count, count_after_pop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_insn [BUF_DEPTH];
  logic          room, pop, push, accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A redirect hides the head immediately so decode never consumes a stale word.
  assign insn_valid      = (count != '0) && !redirect;
  assign pop             = insn_valid && !stall;
  assign count_after_pop = count - CW'(pop);
  // A request is only issued when a slot is guaranteed for its response.
  assign room            = count_after_pop < CW'(BUF_DEPTH);
  assign accept          = memReq && memReady;
  // fetch_pc only moves on accept or redirect, so the address holds while stalled by memReady.
  assign memAddr         = fetch_pc;
  assign insn            = buf_insn[rd_ptr];
  assign pc              = buf_pc[rd_ptr];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: a response arriving with a redirect is the stale word itself,
  // so it retires the outstanding request rather than entering FLUSH.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = WAIT;
      WAIT:  if (memRespValid) state_nx = IDLE;
             else if (redirect) state_nx = FLUSH;
      // Further redirects keep us here; only the stale response ends the flush.
      FLUSH: if (memRespValid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: request only from IDLE, push only the live response in WAIT
  always_comb begin
    memReq = 1'b0;
    push   = 1'b0;
    unique case (state)
      IDLE:    memReq = room && !redirect && !reset;
      WAIT:    push   = memRespValid && !redirect;
      default: ;
    endcase
  end

  // PC, request tag and FIFO storage; redirect clears the queue outright
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= START_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_insn[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirectPc & ~32'd3;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        buf_pc[wr_ptr]   <= req_pc;
        buf_insn[wr_ptr] <= memRespData;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_after_pop + CW'(push);
    end
  end

  // A push into a full queue means the slot reservation was broken.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count == CW'(BUF_DEPTH))))
    else $error("fetch: push into full instruction buffer");

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: sequential fetch, stall fill/drain, redirect with
// flush, memReady back-pressure, PC wrap, and asynchronous reset mid-request.
module tb_fetch;
  logic        clock = 1'b0;
  logic        reset, stall, redirect, memReady, memRespValid;
  logic [31:0] redirectPc, memRespData, memAddr, insn, pc;
  logic        memReq, insn_valid;
  logic        w_req, w_valid, w_rv;
  logic [31:0] w_addr, w_insn, w_pc, w_rd;
  logic [31:0] w_log [2];
  int          w_n;
  int          n_tests = 0, n_fail = 0;
  int          lat;
  int          n;
  localparam logic [31:0] BASE = 32'h8002_0000;

  fetch #(.START_PC(32'h8002_0000), .BUF_DEPTH(2)) u_dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .memReq(memReq), .memAddr(memAddr),
    .memReady(memReady), .memRespValid(memRespValid), .memRespData(memRespData),
    .insn(insn), .pc(pc), .insn_valid(insn_valid));

  fetch #(.START_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
    .clock(clock), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirectPc(32'h0), .memReq(w_req), .memAddr(w_addr),
    .memReady(1'b1), .memRespValid(w_rv), .memRespData(w_rd),
    .insn(w_insn), .pc(w_pc), .insn_valid(w_valid));

  always #5 clock = ~clock;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock); #2;
  endtask

  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    do begin cyc(); #1; cnt++; end while (!insn_valid && cnt < max);
    if (!insn_valid) chk("wait_valid_timeout", {31'd0, insn_valid}, 32'd1);
  endtask

  // Memory model: samples acceptance mid-cycle, answers lat cycles later.
  initial begin : mem_model
    logic acc, w_acc;
    logic [31:0] acc_addr, w_acc_addr, paddr;
    int cnt;
    bit pend;
    memRespValid = 0; memRespData = 0; w_rv = 0; w_rd = 0;
    pend = 0; cnt = 0; paddr = 0; w_n = 0;
    forever begin
      @(negedge clock);
      acc = memReq && memReady; acc_addr = memAddr;
      w_acc = w_req; w_acc_addr = w_addr;
      if (w_acc && w_n < 2) begin w_log[w_n] = w_addr; w_n++; end
      @(posedge clock); #1;
      memRespValid = 0;
      if (acc) begin pend = 1; paddr = acc_addr; cnt = lat; end
      if (pend) begin
        if (cnt <= 1) begin memRespValid = 1; memRespData = img(paddr); pend = 0; end
        else cnt--;
      end
      w_rv = w_acc; w_rd = img(w_acc_addr);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; stall = 0; redirect = 0; redirectPc = 0; memReady = 1; lat = 1;
    #1;
    chk("rst_req", memReq, 0);
    chk("rst_addr", memAddr, BASE);
    chk("rst_valid", insn_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_insn", insn, 0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    cyc(); cyc();
    reset = 0; #1;
    chk("t1_req0", memReq, 1);
    chk("t1_addr0", memAddr, BASE);

    // 1: full-rate sequential fetch, one word every 2 cycles
    for (int k = 0; k < 4; k++) begin
      wait_valid(8, n);
      chk("t1_gap", n, 2);
      chk("t1_pc", pc, BASE + 32'(4 * k));
      chk("t1_insn", insn, img(BASE + 32'(4 * k)));
      chk("t1_next_addr", memAddr, BASE + 32'(4 * k + 4));
    end

    // 2: stall fills the buffer, then drains in order
    stall = 1; #1;
    chk("t2_req_c0", memReq, 1);
    repeat (5) cyc();
    #1;
    chk("t2_full_req", memReq, 0);
    chk("t2_hold_valid", insn_valid, 1);
    chk("t2_hold_pc", pc, BASE + 32'h0C);
    chk("t2_hold_insn", insn, img(BASE + 32'h0C));
    stall = 0; #1;
    chk("t2_rel_req", memReq, 1);
    chk("t2_rel_addr", memAddr, BASE + 32'h14);
    cyc(); #1;
    chk("t2_drain1_valid", insn_valid, 1);
    chk("t2_drain1_pc", pc, BASE + 32'h10);
    cyc(); #1;
    chk("t2_drain2_pc", pc, BASE + 32'h14);
    chk("t2_drain2_addr", memAddr, BASE + 32'h18);

    // 3: redirect while a 3-cycle read is in flight
    lat = 3;
    cyc();
    redirect = 1; redirectPc = 32'h8002_0103; #1;
    chk("t3_redir_req", memReq, 0);
    chk("t3_redir_valid", insn_valid, 0);
    cyc(); redirect = 0; #1;
    chk("t3_flush_req", memReq, 0);
    cyc(); #1;
    chk("t3_stale_req", memReq, 0);
    chk("t3_stale_valid", insn_valid, 0);
    cyc(); #1;
    chk("t3_new_req", memReq, 1);
    chk("t3_new_addr", memAddr, 32'h8002_0100);
    chk("t3_new_valid", insn_valid, 0);
    wait_valid(10, n);
    chk("t3_gap", n, 4);
    chk("t3_pc", pc, 32'h8002_0100);
    chk("t3_insn", insn, img(32'h8002_0100));

    // 4: memReady low for 3 cycles, redirect withdraws the request
    memReady = 0; lat = 1; #1;
    chk("t4_req0", memReq, 1);
    chk("t4_addr0", memAddr, 32'h8002_0104);
    cyc(); #1;
    chk("t4_addr1", memAddr, 32'h8002_0104);
    chk("t4_valid1", insn_valid, 0);
    cyc(); #1;
    chk("t4_addr2", memAddr, 32'h8002_0104);
    redirect = 1; redirectPc = 32'h8002_0200; #1;
    chk("t4_withdrawn", memReq, 0);
    cyc(); redirect = 0; memReady = 1; #1;
    chk("t4_tgt_req", memReq, 1);
    chk("t4_tgt_addr", memAddr, 32'h8002_0200);
    wait_valid(8, n);
    chk("t4_gap", n, 2);
    chk("t4_pc", pc, 32'h8002_0200);
    chk("t4_insn", insn, img(32'h8002_0200));

    // 6: asynchronous reset mid-WAIT with a word still buffered
    stall = 1; lat = 3; #1;
    cyc(); #1;
    chk("t6_pre_valid", insn_valid, 1);
    chk("t6_pre_pc", pc, 32'h8002_0200);
    reset = 1; memReady = 0; #1;
    chk("t6_rst_req", memReq, 0);
    chk("t6_rst_valid", insn_valid, 0);
    chk("t6_rst_pc", pc, 0);
    chk("t6_rst_insn", insn, 0);
    chk("t6_rst_addr", memAddr, BASE);
    reset = 0; stall = 0;
    cyc(); #1;
    chk("t6_idle_req", memReq, 1);
    chk("t6_idle_valid", insn_valid, 0);
    cyc(); #1;
    chk("t6_late_valid", insn_valid, 0);
    cyc(); #1;
    chk("t6_after_late_valid", insn_valid, 0);
    chk("t6_restart_addr", memAddr, BASE);
    memReady = 1; lat = 1; #1;
    wait_valid(8, n);
    chk("t6_gap", n, 2);
    chk("t6_pc", pc, BASE);
    chk("t6_insn", insn, img(BASE));

    // 5: PC wrap on the second instance
    chk("t5_wrap_n", {31'd0, w_n >= 2}, 32'd1);
    chk("t5_wrap_addr0", w_log[0], 32'hFFFF_FFFC);
    chk("t5_wrap_addr1", w_log[1], 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
